// File: rtl/stream_demux_pkt.sv
// Registered 1-to-N_OUT stream demultiplexer with per-packet locked routing.
// Packets addressed past the last channel are consumed and counted as drops.
module stream_demux_pkt #(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    localparam int SEL_W  = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_last,
    input  logic [SEL_W-1:0]        sel,
    output logic [N_OUT-1:0]        m_valid,
    input  logic [N_OUT-1:0]        m_ready,
    output logic [N_OUT*DATA_W-1:0] m_data,
    output logic [N_OUT-1:0]        m_last,
    output logic [15:0]             drop_cnt
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t               state;
    logic [SEL_W-1:0]     lock_sel;
    logic [SEL_W-1:0]     target;
    logic [N_OUT-1:0]     free;
    logic [N_OUT-1:0]     match;
    logic [N_OUT-1:0]     wr;
    logic                 hit;
    logic                 accept;

    assign free   = ~m_valid | m_ready;
    assign target = (state == PASS) ? lock_sel : sel;

    // A target with no matching channel (or the DROP state) is always ready.
    always_comb begin
        s_ready = 1'b1;
        match   = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (state != DROP && target == SEL_W'(i)) begin
                match[i] = 1'b1;
                s_ready  = free[i];
            end
        end
    end

    assign hit    = |match;
    assign accept = s_valid && s_ready;
    assign wr     = accept ? match : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (!s_last) begin
                            lock_sel <= sel;
                            state    <= PASS;
                        end
                    end else begin
                        if (drop_cnt != 16'hFFFF)
                            drop_cnt <= drop_cnt + 16'd1;
                        if (!s_last)
                            state <= DROP;
                    end
                end
                PASS, DROP: begin
                    if (s_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output registers: a write wins over a drain, so a full register refills on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= '0;
            m_last  <= '0;
            m_data  <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr[i]) begin
                    m_valid[i]                  <= 1'b1;
                    m_last[i]                   <= s_last;
                    m_data[i*DATA_W +: DATA_W]  <= s_data;
                end else if (m_ready[i]) begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
